// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and out_ready; slave (the adder) drives in_ready and results.
interface pipelined_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK of carry resolved per stage, valid/ready on both sides.
// Optional macro PIPE_ADD_SAT_EN saturates sum on signed overflow.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);
   localparam int unsigned CHUNK = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   logic [STAGES-1:0] v_q, v_d, c_q, c_d;
   logic [STAGES-1:0] v_in, c_in, adv, ld_ok, ld_en;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [CHUNK:0]    ext;
   logic              nxt_ok;
   logic              ovf_q, ovf_d;

   always_comb begin
      v_in   = '0;
      c_in   = '0;
      adv    = '0;
      ld_ok  = '0;
      ld_en  = '0;
      v_d    = '0;
      c_d    = '0;
      a_in   = '{default: '0};
      b_in   = '{default: '0};
      s_in   = '{default: '0};
      s_d    = '{default: '0};
      ext    = '0;
      ovf_d  = 1'b0;

      // Backpressure ripples from out_ready down to stage 0.
      nxt_ok = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k]   = v_q[k] & nxt_ok;
         ld_ok[k] = ~v_q[k] | adv[k];
         nxt_ok   = ld_ok[k];
      end

      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            v_in[k] = bus.in_valid;
            a_in[k] = bus.a;
            b_in[k] = bus.sub ? ~bus.b : bus.b;
            c_in[k] = bus.sub | bus.cin;
            s_in[k] = '0;
         end else begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
         end
         ld_en[k] = v_in[k] & ld_ok[k];
         v_d[k]   = ld_ok[k] ? v_in[k] : v_q[k];
         ext      = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(c_in[k]);
         s_d[k]   = s_in[k];
         s_d[k][k*CHUNK +: CHUNK] = ext[CHUNK-1:0];
         c_d[k]   = ext[CHUNK];
      end

      ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
              (s_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
`ifdef PIPE_ADD_SAT_EN
      // Overflow direction follows the operand sign (both operands share it).
      if (ovf_d) begin
         s_d[LAST] = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            if (ld_en[k]) begin
               a_q[k] <= a_in[k];
               b_q[k] <= b_in[k];
               s_q[k] <= s_d[k];
               c_q[k] <= c_d[k];
            end
         end
         if (ld_en[LAST]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign bus.in_ready  = ld_ok[0];
   assign bus.out_valid = v_q[LAST];
   assign bus.sum       = s_q[LAST];
   assign bus.cout      = c_q[LAST];
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4): arithmetic model plus scoreboard,
// directed literal vectors, stall, mid-flight reset, throughput and random traffic.
module tb_pipelined_adder;
   localparam int unsigned W = 32;
   localparam int unsigned S = 4;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } res_t;

`ifdef PIPE_ADD_SAT_EN
   localparam logic [W-1:0] SUM3A = 32'h7FFF_FFFF;
   localparam logic [W-1:0] SUM3B = 32'h8000_0000;
`else
   localparam logic [W-1:0] SUM3A = 32'h8000_0000;
   localparam logic [W-1:0] SUM3B = 32'h7FFF_FFFF;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W)) bus ();

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_out  = 0;
   res_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: signed and unsigned views of a + b_eff + c0 using wide integers.
   function automatic res_t model(input logic [W-1:0] av, bv, input logic ci, sb);
      res_t        r;
      logic [W-1:0] be;
      longint      c0, sa, sbe, sr;
      longint unsigned ur;
      be  = sb ? ~bv : bv;
      c0  = (sb || ci) ? 1 : 0;
      sa  = $signed(av);
      sbe = $signed(be);
      sr  = sa + sbe + c0;
      ur  = longint'({32'b0, av}) + longint'({32'b0, be}) + c0;
      r.s = ur[W-1:0];
      r.c = ur[W];
      r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef PIPE_ADD_SAT_EN
      if (r.o) r.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      return r;
   endfunction

   res_t prev;
   logic prev_stall = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
         chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
         if (prev_stall) chk("hold_valid", 64'(bus.out_valid), 64'd1);
         if (bus.out_valid) begin
            chk("output_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("scoreboard", 64'({bus.sum, bus.cout, bus.ovf}), 64'(exp_q[0]));
            if (prev_stall) chk("hold_stable", 64'({bus.sum, bus.cout, bus.ovf}), 64'(prev));
            prev       = {bus.sum, bus.cout, bus.ovf};
            prev_stall = !bus.out_ready;
            if (bus.out_ready && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               n_out++;
            end
         end else begin
            prev_stall = 1'b0;
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
   end

   task automatic directed(input string nm, input logic [W-1:0] av, bv, input logic ci, sb,
                           input logic [W-1:0] es, input logic ec, eo);
      res_t m;
      int   lat;
      m = model(av, bv, ci, sb);
      chk({nm, "_model"}, 64'(m), 64'({es, ec, eo}));
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a   = av;
      bus.b   = bv;
      bus.cin = ci;
      bus.sub = sb;
      @(negedge clk);
      chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(S));
      chk({nm, "_result"}, 64'({bus.sum, bus.cout, bus.ovf}), 64'({es, ec, eo}));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1);
   end

   initial begin
      int idx, base;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_sum", 64'(bus.sum), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      directed("t1_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      directed("t2_sub_lt", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      directed("t2_sub_gt", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      directed("t_cin",     32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
      directed("t3_posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SUM3A, 1'b0, 1'b1);
      directed("t3_negovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, SUM3B, 1'b1, 1'b1);

      // Stream 8 ops with out_ready low for cycles 3..8.
      idx  = 0;
      base = n_out;
      for (int cyc = 0; cyc < 40 && (idx < 8 || n_out < base + 8); cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc <= 8);
         bus.in_valid  = (idx < 8);
         bus.a   = 32'h1111_1111 * idx;
         bus.b   = 32'h1000_0001 * (idx + 1);
         bus.cin = idx[1];
         bus.sub = idx[0];
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) idx++;
         if (cyc == 8) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_held_ops", 64'(idx), 64'(S));
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("stream_all_out", 64'(n_out - base), 64'd8);

      // Three ops in flight, reset mid-cycle.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.a = 32'hA000_0000 + i;
         bus.b = 32'h0000_0100;
         bus.sub = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_reset_no_stale", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      directed("t5_after_rst", 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 1'b0, 1'b0);

      // Full throughput with both sides asserted.
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = 1'b1;
         bus.a   = $urandom;
         bus.b   = $urandom;
         bus.cin = 1'($urandom_range(0, 1));
         bus.sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("thru_in_ready", 64'(bus.in_ready), 64'd1);
         if (i >= int'(S)) chk("thru_out_valid", 64'(bus.out_valid), 64'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;

      // Random traffic with corner operands mixed in.
      for (int i = 0; i < 300; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       bus.a = 32'h7FFF_FFFF;
            1:       bus.a = 32'h8000_0000;
            default: bus.a = $urandom;
         endcase
         bus.b   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         bus.cin = 1'($urandom_range(0, 1));
         bus.sub = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
